// File: rtl/score_submitter.sv
// score_submitter: latches a clamped end-of-game score and player, issues a
// one-cycle submit command to the score tracker, waits a fixed response time,
// captures the tracker's winner flags and shows the result (blinking LED when
// a winner flag is set) until the user acknowledges it.
// All outputs come straight from flops; next-state logic below computes the
// value each output flop takes on the coming edge.

module score_submitter #(
    parameter logic [3:0] SUBMIT_CODE = 4'd5,
    parameter int         RESP_WAIT   = 12,
    parameter int         BLINK_HALF  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_over,
    input  logic [13:0] final_score,
    input  logic [1:0]  player_id,
    input  logic        ack_clear,
    input  logic        personal_winner,
    input  logic        global_winner,
    output logic [13:0] score_out,
    output logic [1:0]  player_out,
    output logic [3:0]  score_req,
    output logic        busy,
    output logic        result_valid,
    output logic        new_personal,
    output logic        new_global,
    output logic        blink_led,
    output logic        invalid_id
);

    localparam int WCW = ($clog2(RESP_WAIT + 1) < 1) ? 1 : $clog2(RESP_WAIT + 1);
    localparam int BCW = ($clog2(BLINK_HALF + 1) < 1) ? 1 : $clog2(BLINK_HALF + 1);

    // The submit command becomes visible in the first WAIT cycle; RESP_WAIT
    // more WAIT cycles follow it before CAPTURE samples the winner flags.
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(RESP_WAIT);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_HALF - 1);
    localparam logic [13:0]    SCORE_MAX  = 14'd9999;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_REQ     = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_SHOW    = 3'd5
    } state_t;

    state_t         state_q,   state_d;
    logic [WCW-1:0] wcnt_q,    wcnt_d;
    logic [BCW-1:0] bcnt_q,    bcnt_d;
    logic [13:0]    score_q,   score_d;
    logic [1:0]     player_q,  player_d;
    logic [3:0]     req_q,     req_d;
    logic           busy_q,    busy_d;
    logic           result_q,  result_d;
    logic           np_q,      np_d;
    logic           ng_q,      ng_d;
    logic           blink_q,   blink_d;
    logic           invalid_q, invalid_d;

    // Saturate scores above the four-digit display range.
    function automatic logic [13:0] clamp_score(input logic [13:0] raw);
        logic [13:0] res;
        if (raw > SCORE_MAX) begin
            res = SCORE_MAX;
        end else begin
            res = raw;
        end
        return res;
    endfunction

    // Next-state and next-output computation for the submit sequence.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        bcnt_d    = bcnt_q;
        score_d   = score_q;
        player_d  = player_q;
        req_d     = 4'd0;
        invalid_d = 1'b0;
        result_d  = result_q;
        np_d      = np_q;
        ng_d      = ng_q;
        blink_d   = blink_q;

        case (state_q)
            ST_IDLE: begin
                if (game_over) begin
                    if (player_id != 2'b00) begin
                        score_d  = clamp_score(final_score);
                        player_d = player_id;
                        state_d  = ST_SETUP;
                    end else begin
                        invalid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                req_d   = SUBMIT_CODE;
                wcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            ST_CAPTURE: begin
                np_d     = personal_winner;
                ng_d     = global_winner;
                result_d = 1'b1;
                blink_d  = personal_winner | global_winner;
                bcnt_d   = '0;
                state_d  = ST_SHOW;
            end
            ST_SHOW: begin
                if (ack_clear) begin
                    result_d = 1'b0;
                    np_d     = 1'b0;
                    ng_d     = 1'b0;
                    blink_d  = 1'b0;
                    bcnt_d   = '0;
                    state_d  = ST_IDLE;
                end else if (np_q | ng_q) begin
                    if (bcnt_q == BLINK_LAST) begin
                        blink_d = ~blink_q;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + BCW'(1);
                    end
                end else begin
                    blink_d = 1'b0;
                end
            end
            default: begin
                result_d = 1'b0;
                np_d     = 1'b0;
                ng_d     = 1'b0;
                blink_d  = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and every output flop; reset aborts any sequence at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            bcnt_q    <= '0;
            score_q   <= 14'd0;
            player_q  <= 2'b00;
            req_q     <= 4'd0;
            busy_q    <= 1'b0;
            result_q  <= 1'b0;
            np_q      <= 1'b0;
            ng_q      <= 1'b0;
            blink_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            bcnt_q    <= bcnt_d;
            score_q   <= score_d;
            player_q  <= player_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            result_q  <= result_d;
            np_q      <= np_d;
            ng_q      <= ng_d;
            blink_q   <= blink_d;
            invalid_q <= invalid_d;
        end
    end

    assign score_out    = score_q;
    assign player_out   = player_q;
    assign score_req    = req_q;
    assign busy         = busy_q;
    assign result_valid = result_q;
    assign new_personal = np_q;
    assign new_global   = ng_q;
    assign blink_led    = blink_q;
    assign invalid_id   = invalid_q;

endmodule

// File: doc/score_submitter.md
SCORE_SUBMITTER -- requirements
Module: score_submitter

Interface
REQ-001 Parameter SUBMIT_CODE, default 4'd5: the command value driven on score_req for one submit.
REQ-002 Parameter RESP_WAIT, default 12: number of cycles from the req pulse to the winner-flag sample.
REQ-003 Parameter BLINK_HALF, default 4: half-period of blink_led, in cycles.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 game_over  input  1  level; sampled only in IDLE.
REQ-007 final_score  input  14  the player's end-of-game score.
REQ-008 player_id  input  2  the current player; 2'b00 means no player.
REQ-009 ack_clear  input  1  user acknowledge that leaves the result display.
REQ-010 personal_winner  input  1  flag from the score tracker.
REQ-011 global_winner  input  1  flag from the score tracker.
REQ-012 score_out  output  14  latched, clamped score presented to the tracker.
REQ-013 player_out  output  2  latched player presented to the tracker.
REQ-014 score_req  output  4  command to the tracker; 0 means idle.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 result_valid  output  1  high while new_personal and new_global hold a captured result.
REQ-017 new_personal, new_global  output  1 each  captured winner flags.
REQ-018 blink_led  output  1  winner indication.
REQ-019 invalid_id  output  1  one-cycle pulse when a submission is rejected.

Function
REQ-020 The FSM SHALL have states IDLE, SETUP, REQ, WAIT, CAPTURE and SHOW, with every output registered.
REQ-021 IDLE: if game_over=1 and player_id!=0, SHALL latch score_out and player_out and go to SETUP.
REQ-022 IDLE: if game_over=1 and player_id=0, SHALL pulse invalid_id for one cycle, stay in IDLE and leave score_out and player_out unchanged.
REQ-023 Clamp: if final_score>9999, score_out SHALL be 9999; otherwise score_out SHALL equal final_score.
REQ-024 SETUP SHALL last 1 cycle with score_req=0, so data is stable for one cycle before the request; it then goes to REQ.
REQ-025 REQ SHALL last exactly 1 cycle with score_req=SUBMIT_CODE; score_req SHALL be 0 in every other state.
REQ-026 score_out and player_out SHALL stay constant from the latch cycle until the FSM returns to IDLE.
REQ-027 WAIT SHALL use a counter cleared on entry and SHALL leave for CAPTURE after RESP_WAIT cycles.
REQ-028 CAPTURE SHALL sample personal_winner and global_winner into new_personal and new_global, set result_valid=1, and go to SHOW after 1 cycle.
REQ-029 Overall latency: game_over sampled at edge N gives score_req=SUBMIT_CODE after edge N+2 and result_valid=1 after edge N+RESP_WAIT+4.
REQ-030 SHOW, when new_personal|new_global=1: blink_led SHALL toggle every BLINK_HALF cycles, starting at 1.
REQ-031 SHOW, when neither flag is set: blink_led SHALL stay 0.
REQ-032 SHOW SHALL hold until ack_clear=1, then go to IDLE; result_valid, new_personal, new_global and blink_led SHALL all be 0 from the next cycle.
REQ-033 game_over asserted in any state other than IDLE SHALL be ignored; nothing is queued.
REQ-034 game_over=1 and ack_clear=1 in the same cycle in SHOW: ack wins and the FSM goes to IDLE; game_over SHALL be captured on the next cycle only if it is still high.
REQ-035 A held game_over SHALL resubmit after each return to IDLE (level-sensitive by design).
REQ-036 ack_clear outside SHOW SHALL have no effect.

Reset
REQ-037 rst=0 SHALL immediately and asynchronously force state=IDLE, clear the counters, and clear every output to 0.
REQ-038 Reset asserted mid-operation (e.g. during REQ or WAIT) SHALL abort with score_req=0 at once and no result captured.
REQ-039 After rst returns high, the first transition SHALL occur on the next rising edge where an IDLE condition holds.

Verification
REQ-040 final_score=100, player_id=01, 1-cycle game_over pulse, personal_winner=1 -> score_req=5 for exactly one cycle 2 cycles after the pulse; result_valid=1 after RESP_WAIT+4 cycles; new_personal=1; blink_led toggles every 4 cycles; ack_clear -> IDLE and all outputs 0.
REQ-041 final_score=88, player_id=01, both winner flags 0 -> result_valid=1, new_personal=new_global=0, blink_led constant 0.
REQ-042 final_score=12000, player_id=10 -> score_out=9999 and player_out=10, both stable through WAIT.
REQ-043 game_over=1 with player_id=00 -> invalid_id one-cycle pulse, busy stays 0, score_req stays 0.
REQ-044 rst driven low during WAIT -> score_req=0, busy=0 and result_valid=0 asynchronously, before the next clock edge.
REQ-045 In SHOW, assert game_over and ack_clear in the same cycle, then keep game_over high -> IDLE for one cycle, then a new submission starts (SETUP).
